// File: rtl/defines_package.sv
// Shared geometry types for the triangle pipeline, plus the scheduler's
// state encoding so checkers and benches can decode its debug output.
package defines_package;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    SEND_RAST = 3'd2,
    SEND_CLIP = 3'd3,
    CULL      = 3'd4
  } tcs_state_e;

endpackage

// File: rtl/tri_check_sched_if.sv
// Handshake and data bundle around the triangle check scheduler.
//
// Handshake rule for every channel here: a transfer happens on a rising
// clk edge where valid and ready are both high; once valid is raised the
// sender holds valid and data unchanged until that transfer.
interface tri_check_sched_if;
  import defines_package::*;

  logic [1:0]      src_valid;
  Triangle3D [1:0] src_tri;
  logic [1:0]      src_ready;

  Triangle3D       chk_tri;
  logic            chk_oob;

  logic            rast_valid;
  logic            rast_ready;
  Triangle3D       rast_tri;

  logic            clip_valid;
  logic            clip_ready;
  Triangle3D       clip_tri;

  modport slave (
    input  src_valid, src_tri, chk_oob, rast_ready, clip_ready,
    output src_ready, chk_tri, rast_valid, rast_tri, clip_valid, clip_tri
  );

  modport master (
    output src_valid, src_tri, chk_oob, rast_ready, clip_ready,
    input  src_ready, chk_tri, rast_valid, rast_tri, clip_valid, clip_tri
  );

endinterface

// File: rtl/tri_check_sched.sv
// Arbitrates two triangle sources onto one shared bounds checker, then
// forwards each triangle to the rasterizer (in bounds), the clipper (out of
// bounds, clipping enabled) or drops it (out of bounds, clipping disabled).
module tri_check_sched
  import defines_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  tri_check_sched_if.slave bus,
  input  logic             clip_en,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_accept,
  output logic [CNT_W-1:0] cnt_clip,
  output logic [CNT_W-1:0] cnt_cull,
  output tcs_state_e       dbg_state,
  output logic             dbg_rr_ptr
);

  tcs_state_e state, state_d;
  logic       rr_ptr;
  Triangle3D  tri_reg;
  logic [1:0] grant;
  logic       grant_idx;
  logic       xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Round-robin grant: a lone requester always wins, a tie goes to rr_ptr.
  always_comb begin
    grant = 2'b00;
    case (bus.src_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Ready only from IDLE, and never while reset is held.
  assign bus.src_ready = (state == IDLE && n_rst) ? grant : 2'b00;
  assign grant_idx     = grant[1];
  assign xfer          = |(bus.src_valid & bus.src_ready);

  // Next-state logic; routing is decided once in CHECK and then frozen.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (xfer) state_d = CHECK;
      CHECK: begin
        if (!bus.chk_oob) state_d = SEND_RAST;
        else if (clip_en) state_d = SEND_CLIP;
        else              state_d = CULL;
      end
      SEND_RAST: if (bus.rast_ready) state_d = IDLE;
      SEND_CLIP: if (bus.clip_ready) state_d = IDLE;
      CULL:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // State register, capture of the granted triangle, and saturating counters.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      tri_reg    <= '0;
      cnt_accept <= '0;
      cnt_clip   <= '0;
      cnt_cull   <= '0;
    end else begin
      state <= state_d;
      if (xfer) begin
        tri_reg    <= bus.src_tri[grant_idx];
        rr_ptr     <= ~grant_idx;
        cnt_accept <= sat_inc(cnt_accept);
      end
      if (state == SEND_CLIP && bus.clip_ready) cnt_clip <= sat_inc(cnt_clip);
      if (state == CULL) cnt_cull <= sat_inc(cnt_cull);
    end
  end

  assign bus.chk_tri    = tri_reg;
  assign bus.rast_tri   = tri_reg;
  assign bus.clip_tri   = tri_reg;
  assign bus.rast_valid = (state == SEND_RAST);
  assign bus.clip_valid = (state == SEND_CLIP);
  assign busy           = (state != IDLE);
  assign dbg_state      = state;
  assign dbg_rr_ptr     = rr_ptr;

endmodule

// File: tb/tb_tri_check_sched.sv
// Directed bench for tri_check_sched. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
module tb_tri_check_sched;
  import defines_package::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic clip_en;
  logic busy;
  logic [CNT_W-1:0] cnt_accept, cnt_clip, cnt_cull;
  tcs_state_e dbg_state;
  logic dbg_rr_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  Triangle3D tri_a, tri_b, tri_c;

  tri_check_sched_if bus ();

  tri_check_sched #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .clip_en    (clip_en),
    .busy       (busy),
    .cnt_accept (cnt_accept),
    .cnt_clip   (cnt_clip),
    .cnt_cull   (cnt_cull),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // clock
  always #5 clk = ~clk;

  function automatic Triangle3D mk_tri(input logic [15:0] base);
    Triangle3D t;
    t.v0.x = base;          t.v0.y = base + 16'd1; t.v0.z = base + 16'd2;
    t.v1.x = base + 16'd3;  t.v1.y = base + 16'd4; t.v1.z = base + 16'd5;
    t.v2.x = base + 16'd6;  t.v2.y = base + 16'd7; t.v2.z = base + 16'd8;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next drive point (1 unit after the rising edge)
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.src_valid  = 2'b00;
    bus.src_tri[0] = '0;
    bus.src_tri[1] = '0;
    bus.chk_oob    = 1'b0;
    bus.rast_ready = 1'b0;
    bus.clip_ready = 1'b0;
    clip_en        = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    n_rst = 1'b1;
  endtask

  initial begin
    tri_a = mk_tri(16'h0100);
    tri_b = mk_tri(16'h0200);
    tri_c = mk_tri(16'h0F00);

    // ---- reset values ----
    do_reset();
    @(negedge clk);
    chk("rst_state", 160'(dbg_state), 160'(IDLE));
    chk("rst_rr_ptr", 160'(dbg_rr_ptr), 160'd0);
    chk("rst_chk_tri", 160'(bus.chk_tri), 160'd0);
    chk("rst_counters", {cnt_accept, cnt_clip, cnt_cull}, 160'd0);
    chk("rst_valids_busy", {bus.rast_valid, bus.clip_valid, busy}, 160'd0);

    // ---- scenario 1: src0 in-bounds triangle to the rasterizer ----
    next_cycle();
    bus.src_valid  = 2'b01;
    bus.src_tri[0] = tri_a;
    bus.rast_ready = 1'b1;
    @(negedge clk);
    chk("s1_c0_src_ready", 160'(bus.src_ready), 160'b01);
    chk("s1_c0_rast_valid", 160'(bus.rast_valid), 160'd0);
    next_cycle();
    bus.src_valid = 2'b00;
    @(negedge clk);
    chk("s1_c1_state", 160'(dbg_state), 160'(CHECK));
    chk("s1_c1_rast_valid", 160'(bus.rast_valid), 160'd0);
    chk("s1_c1_chk_tri", 160'(bus.chk_tri), 160'(tri_a));
    chk("s1_c1_busy", 160'(busy), 160'd1);
    next_cycle();
    @(negedge clk);
    chk("s1_c2_rast_valid", 160'(bus.rast_valid), 160'd1);
    chk("s1_c2_rast_tri", 160'(bus.rast_tri), 160'(tri_a));
    chk("s1_c2_clip_valid", 160'(bus.clip_valid), 160'd0);
    next_cycle();
    @(negedge clk);
    chk("s1_c3_rast_valid", 160'(bus.rast_valid), 160'd0);
    chk("s1_c3_cnt_accept", 160'(cnt_accept), 160'd1);
    chk("s1_c3_cnt_clip_cull", {cnt_clip, cnt_cull}, 160'd0);
    chk("s1_c3_state", 160'(dbg_state), 160'(IDLE));

    // ---- scenario 2: both sources valid, round-robin 0,1,0,1 ----
    do_reset();
    bus.src_valid  = 2'b11;
    bus.src_tri[0] = tri_a;
    bus.src_tri[1] = tri_b;
    bus.rast_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("s2_src_ready", 160'(bus.src_ready),
          (k % 3 != 0) ? 160'b00 : (((k / 3) % 2 == 1) ? 160'b10 : 160'b01));
      chk("s2_not_both", 160'(bus.src_ready == 2'b11), 160'd0);
      if (k % 3 == 2)
        chk("s2_rast_tri", 160'(bus.rast_tri),
            ((k / 3) % 2 == 1) ? 160'(tri_b) : 160'(tri_a));
      next_cycle();
    end
    bus.src_valid = 2'b00;
    @(negedge clk);
    chk("s2_cnt_accept", 160'(cnt_accept), 160'd4);

    // ---- scenario 3: out of bounds to a stalled clipper ----
    do_reset();
    bus.src_valid  = 2'b01;
    bus.src_tri[0] = tri_c;
    bus.chk_oob    = 1'b1;
    clip_en        = 1'b1;
    @(negedge clk);
    chk("s3_c0_src_ready", 160'(bus.src_ready), 160'b01);
    next_cycle();
    @(negedge clk);
    chk("s3_c1_state", 160'(dbg_state), 160'(CHECK));
    for (int c = 2; c <= 7; c++) begin
      next_cycle();
      if (c == 3) begin
        clip_en        = 1'b0;  // must not reroute
        bus.rast_ready = 1'b1;  // wrong channel's ready, must be ignored
        bus.chk_oob    = 1'b0;
      end
      if (c == 7) begin
        bus.clip_ready = 1'b1;
        bus.src_valid  = 2'b00;
      end
      @(negedge clk);
      chk("s3_clip_valid", 160'(bus.clip_valid), 160'd1);
      chk("s3_clip_tri", 160'(bus.clip_tri), 160'(tri_c));
      chk("s3_src_ready", 160'(bus.src_ready), 160'b00);
      chk("s3_rast_valid", 160'(bus.rast_valid), 160'd0);
    end
    next_cycle();
    bus.clip_ready = 1'b0;
    bus.rast_ready = 1'b0;
    @(negedge clk);
    chk("s3_after_clip_valid", 160'(bus.clip_valid), 160'd0);
    chk("s3_cnt_clip", 160'(cnt_clip), 160'd1);
    chk("s3_cnt_accept", 160'(cnt_accept), 160'd1);
    chk("s3_cnt_cull", 160'(cnt_cull), 160'd0);

    // ---- scenario 4: out of bounds, clipping disabled -> cull ----
    do_reset();
    bus.src_valid  = 2'b01;
    bus.src_tri[0] = tri_b;
    bus.chk_oob    = 1'b1;
    clip_en        = 1'b0;
    bus.rast_ready = 1'b1;
    bus.clip_ready = 1'b1;
    next_cycle();
    bus.src_valid = 2'b00;
    next_cycle();
    @(negedge clk);
    chk("s4_c2_state", 160'(dbg_state), 160'(CULL));
    chk("s4_c2_valids", {bus.rast_valid, bus.clip_valid}, 160'd0);
    chk("s4_c2_busy", 160'(busy), 160'd1);
    next_cycle();
    @(negedge clk);
    chk("s4_c3_state", 160'(dbg_state), 160'(IDLE));
    chk("s4_c3_busy", 160'(busy), 160'd0);
    chk("s4_c3_cnt_cull", 160'(cnt_cull), 160'd1);
    chk("s4_c3_cnt_clip", 160'(cnt_clip), 160'd0);

    // ---- scenario 5: reset while stalled in SEND_RAST ----
    do_reset();
    bus.src_valid  = 2'b01;
    bus.src_tri[0] = tri_a;
    bus.chk_oob    = 1'b0;
    next_cycle();
    bus.src_valid = 2'b00;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("s5_stalled_rast_valid", 160'(bus.rast_valid), 160'd1);
    chk("s5_stalled_rr_ptr", 160'(dbg_rr_ptr), 160'd1);
    next_cycle();
    n_rst         = 1'b0;
    bus.src_valid = 2'b01;
    @(negedge clk);
    chk("s5_src_ready_in_reset", 160'(bus.src_ready), 160'b00);
    next_cycle();
    n_rst         = 1'b1;
    bus.src_valid = 2'b00;
    @(negedge clk);
    chk("s5_rast_valid", 160'(bus.rast_valid), 160'd0);
    chk("s5_busy", 160'(busy), 160'd0);
    chk("s5_counters", {cnt_accept, cnt_clip, cnt_cull}, 160'd0);
    chk("s5_rr_ptr", 160'(dbg_rr_ptr), 160'd0);
    chk("s5_chk_tri", 160'(bus.chk_tri), 160'd0);

    // ---- scenario 6: 17 triangles saturate a 4-bit counter ----
    do_reset();
    bus.src_valid  = 2'b01;
    bus.src_tri[0] = tri_b;
    bus.rast_ready = 1'b1;
    for (int i = 0; i < 51; i++) next_cycle();
    bus.src_valid = 2'b00;
    @(negedge clk);
    chk("s6_cnt_accept_sat", 160'(cnt_accept), 160'd15);
    chk("s6_cnt_cull", 160'(cnt_cull), 160'd0);
    chk("s6_state", 160'(dbg_state), 160'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
